// File: rtl/gerador_jogadas.sv
// rtl/gerador_jogadas.sv - scripted move player driving one-hot button presses into jogao_da_velha
// Optional request timeout in ESPERA: define GERADOR_JOGADAS_TIMEOUT_EN.
module gerador_jogadas #(
    parameter int HOLD_CYCLES    = 20,
    parameter int GAP_CYCLES     = 10,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     escreve,
    input  logic [3:0]               jogada,
    input  logic                     limpa,
    input  logic                     iniciar,
    input  logic                     jogar_macro,
    input  logic                     jogar_micro,
    output logic [8:0]               botoes,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     cheio,
    output logic                     erro,
    output logic [$clog2(DEPTH):0]   db_indice,
    output logic [2:0]               db_estado
);

    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = AW + 1;
    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef GERADOR_JOGADAS_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [IW-1:0] DEPTH_V   = IW'(DEPTH);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESPERA    = 3'd1,
        PRESSIONA = 3'd2,
        SOLTA     = 3'd3,
        FIM       = 3'd4,
        ERRO      = 3'd5
    } estado_t;

    estado_t       estado, estado_n;
    logic [IW-1:0] count, count_n;
    logic [IW-1:0] indice, indice_n, indice_inc;
    logic [CW-1:0] cnt, cnt_n;
    logic [8:0]    botoes_n;
    logic          erro_n;
    logic          mem_we;
    logic [3:0]    mem [DEPTH];
    logic [3:0]    mem_rd;
    logic          pedido;
    logic          codigo_ok;

    assign mem_rd     = mem[indice[AW-1:0]];
    assign indice_inc = indice + 1'b1;
    // Both request lines together are still a single request.
    assign pedido     = jogar_macro | jogar_micro;
    assign codigo_ok  = (jogada >= 4'd1) && (jogada <= 4'd9);

    assign cheio     = (count == DEPTH_V);
    assign ocupado   = (estado == ESPERA) || (estado == PRESSIONA) || (estado == SOLTA);
    assign pronto    = (estado == FIM);
    assign db_indice = indice;
    assign db_estado = estado;

    always_comb begin
        estado_n = estado;
        count_n  = count;
        indice_n = indice;
        cnt_n    = cnt;
        botoes_n = botoes;
        erro_n   = 1'b0;
        mem_we   = 1'b0;
        case (estado)
            OCIOSO, FIM: begin
                if (limpa) begin
                    count_n = '0;
                end else if (escreve) begin
                    if (codigo_ok && !cheio) begin
                        mem_we  = 1'b1;
                        count_n = count + 1'b1;
                    end else begin
                        erro_n = 1'b1;
                    end
                end
                if (iniciar) begin
                    indice_n = '0;
                    cnt_n    = '0;
                    estado_n = (count_n != '0) ? ESPERA : FIM;
                end
            end
            ESPERA: begin
                if (pedido) begin
                    estado_n = PRESSIONA;
                    cnt_n    = '0;
                    botoes_n = 9'b1 << (mem_rd - 4'd1);
                end
`ifdef GERADOR_JOGADAS_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    estado_n = ERRO;
                    erro_n   = 1'b1;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            PRESSIONA: begin
                if (cnt == HOLD_LAST) begin
                    estado_n = SOLTA;
                    cnt_n    = '0;
                    botoes_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SOLTA: begin
                if (cnt == GAP_LAST) begin
                    cnt_n    = '0;
                    indice_n = indice_inc;
                    estado_n = (indice_inc == count) ? FIM : ESPERA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ERRO: begin
                botoes_n = '0;
                if (iniciar) begin
                    indice_n = '0;
                    cnt_n    = '0;
                    estado_n = (count != '0) ? ESPERA : FIM;
                end
            end
            default: begin
                estado_n = OCIOSO;
                botoes_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            count  <= '0;
            indice <= '0;
            cnt    <= '0;
            botoes <= '0;
            erro   <= 1'b0;
        end else begin
            estado <= estado_n;
            count  <= count_n;
            indice <= indice_n;
            cnt    <= cnt_n;
            botoes <= botoes_n;
            erro   <= erro_n;
        end
    end

    // Move memory keeps its contents across reset; only count is cleared.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[count[AW-1:0]] <= jogada;
        end
    end

endmodule
